axi_lite_sram_slave: RTL and testbench
======================================

Name: axi_lite_sram_slave

Overview:
AXI4-Lite-style memory slave that sits directly downstream of the core's load/store unit and serves its AR/R and AW/W/B channels. It holds a synthesizable word-addressed SRAM array with independent read and write state machines and a programmable response latency. Data is right-aligned: the slave applies the byte offset from addr[1:0] to data and strobes.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two.
ADDR_W, 32, byte address width.
BASE, 32'h8000_0000, byte address of word 0.
RD_LAT, 1, cycles from AR handshake to first rvalid; must be at least 1.
WR_LAT, 1, cycles from W handshake to first bvalid; must be at least 1.

Ports:
- clock  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- araddr  in  ADDR_W  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address accept.
- rdata  out  32  read data, right-aligned.
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- rvalid  out  1  read data valid.
- rready  in  1  master accepts read data.
- awaddr  in  ADDR_W  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address accept.
- wdata  in  32  write data, right-aligned.
- wstrb  in  4  byte strobes, low-aligned (0001, 0011 or 1111).
- wvalid  in  1  write data valid.
- wready  out  1  write data accept.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts response.

Behaviour:
- Reset: rstate=R_IDLE, wstate=W_IDLE. Outputs are 0 while reset is high: rvalid, bvalid, rdata, rresp, bresp, arready, awready, wready. SRAM contents are not reset.
- Ready signals:
  - arready = (rstate==R_IDLE) && !reset.
  - awready = (wstate==W_IDLE) && !reset.
  - wready = (wstate==W_DATA).
- Handshakes: a transfer occurs on a clock edge where valid && ready. A slave output held valid stays stable until its handshake. No combinational path from input valids to output valids.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP.
  - R_IDLE -> R_WAIT on AR handshake. Latch the address and load cnt=RD_LAT-1.
  - R_WAIT decrements cnt. At 0, read the array, set rvalid=1, go to R_RESP. Result: rvalid is first high RD_LAT cycles after the AR edge.
  - R_RESP holds rdata/rresp. On rready: rvalid<=0, back to R_IDLE. The next AR can be accepted the cycle after.
- Read data: rdata = word >> (8*addr[1:0]), zero-filled. Address decode is idx = (addr-BASE)>>2. If idx>=DEPTH or addr<BASE: rresp=11 and rdata=0.
- Write FSM: W_IDLE -> W_DATA -> W_WAIT -> W_RESP.
  - W_IDLE -> W_DATA on AW handshake.
  - W_DATA -> W_WAIT on W handshake. Latch wdata/wstrb and load cnt=WR_LAT-1.
  - W_WAIT: at cnt 0 perform the write and set bvalid=1.
  - W_RESP: on bready, bvalid<=0 and return to W_IDLE.
- Write alignment:
  - Shifted strobe s = wstrb << addr[1:0] (7-bit).
  - If s[6:4] != 0 (crosses word boundary): bresp=10 and no write.
  - Out of range: bresp=11 and no write.
  - Otherwise write byte lanes s[3:0] with wdata << 8*addr[1:0]; bresp=00.
- Concurrency:
  - Read and write FSMs are fully independent.
  - Same-cycle read and write to one word: the read returns the pre-write value.
  - AW and W are never accepted in the same cycle; W waits for W_DATA.
  - wstrb=0000 is OKAY with no write.
- Reset mid-transaction aborts both FSMs to IDLE and drops all valids. A write not yet committed by W_WAIT is lost.

Optional Feature:
RAND_DELAY_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. On each AR or W handshake, lfsr[2:0] is added to the loaded cnt, giving 0-7 extra cycles.
- Undefined: latencies are exactly RD_LAT and WR_LAT, and no LFSR is instantiated.

Decomposition:
- Shared package axi_lite_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - read-state enum R_IDLE/R_WAIT/R_RESP and write-state enum W_IDLE/W_DATA/W_WAIT/W_RESP.
- One natural sub-module: lfsr16, instantiated only under RAND_DELAY_EN.

Test Plan:
1. Write then read, in range: AW 0x8000_0010 + W 0xDEADBEEF/1111, then AR 0x8000_0010 -> bresp=00; rdata=0xDEADBEEF, rresp=00; rvalid exactly RD_LAT cycles after the AR edge.
2. Byte write at offset 1: AW 0x8000_0021 + W 0x000000AB/0001 over a word holding 0x11223344 -> word becomes 0x1122AB44. AR 0x8000_0021 -> rdata=0x001122AB.
3. Boundary crossing and out of range:
   - Halfword write at 0x8000_0003 (strb 0011) -> bresp=10, memory unchanged.
   - AR BASE+4*DEPTH -> rresp=11, rdata=0.
4. Backpressure: hold rready=0 for 5 cycles -> rvalid and rdata stable and arready=0 throughout. Repeat with bready=0 -> bvalid stable, awready=0.
5. Concurrency and reset:
   - Read and write to the same word issued concurrently -> the read returns the old value.
   - Reset asserted in W_WAIT -> all valids 0 next cycle, memory unchanged, both readies 1 after release.
6. With RAND_DELAY_EN: 1000 random R/W ops checked against a reference model. Observed latency stays in RD_LAT..RD_LAT+7, and the seed sequence is identical across runs.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite SRAM slave.
// Holds the response codes and the read and write FSM state types.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_WAIT,
    W_RESP
  } wstate_e;

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite bus bundle between the load/store unit (master) and the SRAM slave.
// Carries the AR/R and AW/W/B channels. Clock and reset are not part of the bundle.
//   master modport: drives the addresses, valids, write data/strobes, rready and bready
//   slave modport : drives the readies, read data/response and write response
interface axi_lite_sram_slave_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with 16'hACE1 on reset.
// Advances every cycle; used to add random extra response latency.
//   clock   : clock
//   reset   : synchronous, active-high
//   state_o : current LFSR state
module lfsr16 (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state_o
);
  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= 16'hACE1;
    else       state_q <= state_d;
  end

  assign state_o = state_q;
endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite word-addressed SRAM slave with independent read and write FSMs and
// programmable response latency. Data and strobes are right-aligned on the bus and
// shifted into the word by addr[1:0] inside the slave.
//   clock, reset : clock; synchronous active-high reset (SRAM contents not reset)
//   bus          : AXI4-Lite slave modport (AR/R, AW/W/B channels)
// Build option: define RAND_DELAY_EN to add 0-7 LFSR-driven cycles to each latency.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned       DEPTH  = 1024,
  parameter int unsigned       ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int unsigned       RD_LAT = 1,
  parameter int unsigned       WR_LAT = 1
) (
  input logic                  clock,
  input logic                  reset,
  axi_lite_sram_slave_if.slave bus
);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = 16;

  logic [31:0] mem_q [DEPTH];

  rstate_e           rstate_q, rstate_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [CntW-1:0]   rcnt_q, rcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rvalid_q, rvalid_d;

  wstate_e           wstate_q, wstate_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              bvalid_q, bvalid_d;

  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wword;
  logic [6:0]        wshift;
  logic [2:0]        lat_extra;

`ifdef RAND_DELAY_EN
  logic [15:0] lfsr_state;
  logic        unused_lfsr;
  lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .state_o(lfsr_state)
  );
  assign lat_extra   = lfsr_state[2:0];
  assign unused_lfsr = ^lfsr_state[15:3];
`else
  assign lat_extra = 3'd0;
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return (addr >= BASE) && ((off >> 2) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IdxW'((addr - BASE) >> 2);
  endfunction

  // Read FSM
  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rcnt_d   = rcnt_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          raddr_d  = bus.araddr;
          rcnt_d   = CntW'(RD_LAT - 1) + CntW'(lat_extra);
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rvalid_d = 1'b1;
          rstate_d = R_RESP;
          if (in_range(raddr_q)) begin
            rdata_d = mem_q[word_idx(raddr_q)] >> {raddr_q[1:0], 3'b000};
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_DECERR;
          end
        end else begin
          rcnt_d = rcnt_q - CntW'(1);
        end
      end
      R_RESP: begin
        if (bus.rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write FSM; AW and W are taken in separate states so they never handshake together
  always_comb begin
    wstate_d  = wstate_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wword = '0;
    // Bits [6:4] set means the access spills into the next word
    wshift    = 7'(wstrb_q) << waddr_q[1:0];
    unique case (wstate_q)
      W_IDLE: begin
        if (bus.awvalid) begin
          waddr_d  = bus.awaddr;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.wvalid) begin
          wdata_d  = bus.wdata;
          wstrb_d  = bus.wstrb;
          wcnt_d   = CntW'(WR_LAT - 1) + CntW'(lat_extra);
          wstate_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          bvalid_d = 1'b1;
          wstate_d = W_RESP;
          if (wshift[6:4] != '0) begin
            bresp_d = RESP_SLVERR;
          end else if (!in_range(waddr_q)) begin
            bresp_d = RESP_DECERR;
          end else begin
            bresp_d   = RESP_OKAY;
            // A reset landing on the commit edge drops the write
            mem_we    = !reset;
            mem_be    = wshift[3:0];
            mem_wword = wdata_q << {waddr_q[1:0], 3'b000};
          end
        end else begin
          wcnt_d = wcnt_q - CntW'(1);
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rcnt_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wcnt_q   <= '0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rcnt_q   <= rcnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wcnt_q   <= wcnt_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
    end
  end

  // SRAM array: byte-lane writes, no reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= mem_wword[8*b +: 8];
      end
    end
  end

  // All outputs forced low while reset is held
  assign bus.arready = (rstate_q == R_IDLE) && !reset;
  assign bus.awready = (wstate_q == W_IDLE) && !reset;
  assign bus.wready  = (wstate_q == W_DATA) && !reset;
  assign bus.rvalid  = rvalid_q && !reset;
  assign bus.bvalid  = bvalid_q && !reset;
  assign bus.rdata   = reset ? '0 : rdata_q;
  assign bus.rresp   = reset ? '0 : rresp_q;
  assign bus.bresp   = reset ? '0 : bresp_q;
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed self-checking bench for axi_lite_sram_slave (default build, RD_LAT=WR_LAT=1).
module tb_axi_lite_sram_slave;
  import axi_lite_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_lite_sram_slave_if #(.ADDR_W(32)) bus ();

  axi_lite_sram_slave #(
    .DEPTH (1024),
    .ADDR_W(32),
    .BASE  (32'h8000_0000),
    .RD_LAT(1),
    .WR_LAT(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold, output logic [1:0] resp);
    int n;
    @(negedge clock);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clock); n++; end
    check_eq("aw_ready", 32'(bus.awready), 32'd1);
    @(negedge clock);
    bus.awvalid = 1'b0;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    n = 0;
    while (!bus.wready && n < 50) begin @(negedge clock); n++; end
    check_eq("w_ready", 32'(bus.wready), 32'd1);
    @(negedge clock);
    bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clock); n++; end
    check_eq("b_valid", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_eq("b_hold_valid", 32'(bus.bvalid), 32'd1);
      check_eq("b_hold_resp", 32'(bus.bresp), 32'(resp));
      check_eq("b_hold_awready", 32'(bus.awready), 32'd0);
    end
    bus.bready = 1'b1;
    @(negedge clock);
    bus.bready = 1'b0;
    check_eq("b_drop", 32'(bus.bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    @(negedge clock);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clock); n++; end
    check_eq("ar_ready", 32'(bus.arready), 32'd1);
    @(negedge clock);
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 50) begin @(negedge clock); lat++; end
    check_eq("r_valid", 32'(bus.rvalid), 32'd1);
    data = bus.rdata;
    resp = bus.rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_eq("r_hold_valid", 32'(bus.rvalid), 32'd1);
      check_eq("r_hold_data", bus.rdata, data);
      check_eq("r_hold_arready", 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    @(negedge clock);
    bus.rready = 1'b0;
    check_eq("r_drop", 32'(bus.rvalid), 32'd0);
  endtask

  task automatic check_lat(input string tag, input int lat);
`ifdef RAND_DELAY_EN
    check_eq(tag, 32'(lat >= 1 && lat <= 8), 32'd1);
`else
    check_eq(tag, 32'(lat), 32'd1);
`endif
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          n;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check_eq("rst_arready", 32'(bus.arready), 32'd0);
    check_eq("rst_awready", 32'(bus.awready), 32'd0);
    check_eq("rst_wready", 32'(bus.wready), 32'd0);
    check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("rst_bvalid", 32'(bus.bvalid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_arready", 32'(bus.arready), 32'd1);
    check_eq("post_rst_awready", 32'(bus.awready), 32'd1);

    // Full-word write then read back
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, r);
    check_eq("t1_bresp", 32'(r), 32'(RESP_OKAY));
    do_read(32'h8000_0010, 0, d, r, lat);
    check_eq("t1_rdata", d, 32'hDEAD_BEEF);
    check_eq("t1_rresp", 32'(r), 32'(RESP_OKAY));
    check_lat("t1_lat", lat);

    // Byte write at offset 1
    do_write(32'h8000_0020, 32'h1122_3344, 4'b1111, 0, r);
    do_write(32'h8000_0021, 32'h0000_00AB, 4'b0001, 0, r);
    check_eq("t2_bresp", 32'(r), 32'(RESP_OKAY));
    do_read(32'h8000_0020, 0, d, r, lat);
    check_eq("t2_word", d, 32'h1122_AB44);
    do_read(32'h8000_0021, 0, d, r, lat);
    check_eq("t2_rdata_off1", d, 32'h0011_22AB);

    // Boundary crossing, aligned halfword, empty strobe, out of range
    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'b1111, 0, r);
    do_write(32'h8000_0003, 32'h0000_5555, 4'b0011, 0, r);
    check_eq("t3_cross_bresp", 32'(r), 32'(RESP_SLVERR));
    do_read(32'h8000_0000, 0, d, r, lat);
    check_eq("t3_cross_unchanged", d, 32'hCAFE_F00D);
    do_write(32'h8000_0002, 32'h0000_BEEF, 4'b0011, 0, r);
    check_eq("t3_half_bresp", 32'(r), 32'(RESP_OKAY));
    do_read(32'h8000_0002, 0, d, r, lat);
    check_eq("t3_half_rdata", d, 32'h0000_BEEF);
    do_write(32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 0, r);
    check_eq("t3_nostrb_bresp", 32'(r), 32'(RESP_OKAY));
    do_read(32'h8000_0000, 0, d, r, lat);
    check_eq("t3_nostrb_word", d, 32'hBEEF_F00D);
    do_read(32'h8000_1000, 0, d, r, lat);
    check_eq("t3_oor_rresp", 32'(r), 32'(RESP_DECERR));
    check_eq("t3_oor_rdata", d, 32'h0000_0000);
    do_read(32'h7FFF_FFFC, 0, d, r, lat);
    check_eq("t3_below_rresp", 32'(r), 32'(RESP_DECERR));
    do_write(32'h8000_1000, 32'h1234_5678, 4'b1111, 0, r);
    check_eq("t3_oor_bresp", 32'(r), 32'(RESP_DECERR));

    // Backpressure on R and B
    do_read(32'h8000_0010, 5, d, r, lat);
    check_eq("t4_rdata", d, 32'hDEAD_BEEF);
    do_write(32'h8000_0030, 32'h0BAD_CAFE, 4'b1111, 5, r);
    check_eq("t4_bresp", 32'(r), 32'(RESP_OKAY));

    // Read samples the word on the same edge the write commits: old value returned
    @(negedge clock);
    bus.awaddr  = 32'h8000_0010;
    bus.awvalid = 1'b1;
    @(negedge clock);
    bus.awvalid = 1'b0;
    bus.wdata   = 32'h1234_5678;
    bus.wstrb   = 4'b1111;
    bus.wvalid  = 1'b1;
    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    check_eq("t5_wready", 32'(bus.wready), 32'd1);
    check_eq("t5_arready", 32'(bus.arready), 32'd1);
    @(negedge clock);
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    n = 0;
    while (!(bus.rvalid && bus.bvalid) && n < 50) begin @(negedge clock); n++; end
    check_eq("t5_rvalid", 32'(bus.rvalid), 32'd1);
    check_eq("t5_bvalid", 32'(bus.bvalid), 32'd1);
    check_eq("t5_old_value", bus.rdata, 32'hDEAD_BEEF);
    check_eq("t5_bresp", 32'(bus.bresp), 32'(RESP_OKAY));
    bus.rready = 1'b1;
    bus.bready = 1'b1;
    @(negedge clock);
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    do_read(32'h8000_0010, 0, d, r, lat);
    check_eq("t5_new_value", d, 32'h1234_5678);

    // Reset while the write sits in W_WAIT and a read response is pending
    @(negedge clock);
    bus.awaddr  = 32'h8000_0010;
    bus.awvalid = 1'b1;
    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    @(negedge clock);
    bus.awvalid = 1'b0;
    bus.arvalid = 1'b0;
    bus.wdata   = 32'hFFFF_FFFF;
    bus.wstrb   = 4'b1111;
    bus.wvalid  = 1'b1;
    @(negedge clock);
    bus.wvalid = 1'b0;
    check_eq("t5r_pending_rvalid", 32'(bus.rvalid), 32'd1);
    check_eq("t5r_bvalid_pre", 32'(bus.bvalid), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("t5r_arready_in_rst", 32'(bus.arready), 32'd0);
    @(negedge clock);
    check_eq("t5r_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("t5r_bvalid", 32'(bus.bvalid), 32'd0);
    check_eq("t5r_wready", 32'(bus.wready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("t5r_arready", 32'(bus.arready), 32'd1);
    check_eq("t5r_awready", 32'(bus.awready), 32'd1);
    check_eq("t5r_rvalid_after", 32'(bus.rvalid), 32'd0);
    check_eq("t5r_bvalid_after", 32'(bus.bvalid), 32'd0);
    do_read(32'h8000_0010, 0, d, r, lat);
    check_eq("t5r_mem_unchanged", d, 32'h1234_5678);
    do_read(32'h8000_0030, 0, d, r, lat);
    check_eq("t5r_other_word", d, 32'h0BAD_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
